// File: rtl/interrupt_pkg.sv
// Shared types and sizing for the interrupt dispatch path.
// Imported by the dispatcher, its priority picker and the dispatcher interface.
package interrupt_pkg;

   localparam int IRQ_N  = 8;
   localparam int IRQ_IW = $clog2(IRQ_N);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      CLEAR   = 2'd2,
      SERVICE = 2'd3
   } dispatch_state_e;

endpackage

// File: rtl/interrupt_dispatcher_if.sv
// Signals between the dispatcher, the interrupt storage block, CP0 Status and the exception unit.
// master is the dispatcher side; slave is the environment driving pending/mask/handshake.
interface interrupt_dispatcher_if
   import interrupt_pkg::*;
#(
   parameter int N  = IRQ_N,
   parameter int IW = $clog2(N)
);

   logic [N-1:0]  pending;
   logic [N-1:0]  im;
   logic          ie;
   logic          exl;
   logic          ack;
   logic          eret;
   logic          req;
   logic [IW-1:0] irq_id;
   logic [N-1:0]  cause_ip;
   logic          clear;
   logic          busy;

   modport master (
      input  pending, im, ie, exl, ack, eret,
      output req, irq_id, cause_ip, clear, busy
   );

   modport slave (
      output pending, im, ie, exl, ack, eret,
      input  req, irq_id, cause_ip, clear, busy
   );

endinterface

// File: rtl/interrupt_priority_picker.sv
// Combinational picker: returns the first set bit of eligible, searching downward
// from index start and wrapping from 0 to N-1.
module interrupt_priority_picker
   import interrupt_pkg::*;
#(
   parameter int N  = IRQ_N,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  eligible,
   input  logic [IW-1:0] start,
   output logic          valid,
   output logic [IW-1:0] index
);

   // The first hit along the descending, wrapping search order wins.
   always_comb begin
      logic [IW-1:0] pos;
      valid = 1'b0;
      index = '0;
      pos   = '0;
      for (int k = 0; k < N; k++) begin
         pos = IW'((int'(start) + N - k) % N);
         if (!valid && eligible[pos]) begin
            valid = 1'b1;
            index = pos;
         end
      end
   end

endmodule

// File: rtl/interrupt_dispatcher.sv
// Gates the pending vector with Status IM/IE/EXL, requests one interrupt from the exception
// unit, pulses clear after ack and holds until ERET. INTERRUPT_DISPATCH_ROUND_ROBIN_EN selects rotating priority.
module interrupt_dispatcher
   import interrupt_pkg::*;
#(
   parameter int N  = IRQ_N,
   parameter int IW = $clog2(N)
) (
   input  logic clk,
   input  logic reset,
   interrupt_dispatcher_if.master bus
);

   dispatch_state_e state;
   dispatch_state_e state_next;

   logic [N-1:0]  eligible;
   logic          allowed;
   logic [IW-1:0] start;
   logic          pick_valid;
   logic [IW-1:0] pick_index;

   logic          req;
   logic          clear;
   logic          busy;
   logic [IW-1:0] irq_id;
   logic [N-1:0]  cause_ip;

   assign eligible = bus.pending & bus.im;
   assign allowed  = bus.ie & ~bus.exl;

`ifdef INTERRUPT_DISPATCH_ROUND_ROBIN_EN
   logic [IW-1:0] last_id;

   // Search begins just below the last serviced line; last_id of 0 wraps to N-1.
   assign start = (last_id == '0) ? IW'(N - 1) : last_id - 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_id <= '0;
      end else if (state == REQ && state_next == CLEAR) begin
         last_id <= irq_id;
      end
   end
`else
   assign start = IW'(N - 1);
`endif

   interrupt_priority_picker #(
      .N  (N),
      .IW (IW)
   ) u_picker (
      .eligible (eligible),
      .start    (start),
      .valid    (pick_valid),
      .index    (pick_index)
   );

   // Next-state logic; ack takes precedence over withdrawing the request.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (allowed && pick_valid) begin
               state_next = REQ;
            end
         end
         REQ: begin
            if (bus.ack) begin
               state_next = CLEAR;
            end else if (!allowed || !pick_valid) begin
               state_next = IDLE;
            end
         end
         CLEAR: begin
            state_next = SERVICE;
         end
         SERVICE: begin
            if (bus.eret) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they appear registered alongside it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         req      <= 1'b0;
         clear    <= 1'b0;
         busy     <= 1'b0;
         irq_id   <= '0;
         cause_ip <= '0;
      end else begin
         state <= state_next;
         req   <= (state_next == REQ);
         clear <= (state_next == CLEAR);
         busy  <= (state_next != IDLE);
         if (state == IDLE && state_next == REQ) begin
            irq_id   <= pick_index;
            cause_ip <= bus.pending;
         end
      end
   end

   assign bus.req      = req;
   assign bus.clear    = clear;
   assign bus.busy     = busy;
   assign bus.irq_id   = irq_id;
   assign bus.cause_ip = cause_ip;

endmodule

// File: tb/tb_interrupt_dispatcher.sv
// Directed bench for interrupt_dispatcher: a per-cycle vector table plus hand-written
// sequences for asynchronous reset and the priority rotation across service rounds.
module tb_interrupt_dispatcher;
   import interrupt_pkg::*;

   typedef struct {
      logic [7:0] pending;
      logic [7:0] im;
      logic       ie;
      logic       exl;
      logic       ack;
      logic       eret;
      logic       req;
      logic [2:0] irq_id;
      logic [7:0] cause_ip;
      logic       clear;
      logic       busy;
   } vec_t;

   localparam int NUM_VECS = 20;

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   vec_t vecs [NUM_VECS];
   logic [2:0] rr_exp [3];

   interrupt_dispatcher_if #(.N(IRQ_N)) bus ();

   interrupt_dispatcher #(.N(IRQ_N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_stimulus(input logic [7:0] pending, input logic [7:0] im,
                                 input logic ie, input logic exl,
                                 input logic ack, input logic eret);
      bus.pending = pending;
      bus.im      = im;
      bus.ie      = ie;
      bus.exl     = exl;
      bus.ack     = ack;
      bus.eret    = eret;
   endtask

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic check_all(input string tag, input logic req, input logic [2:0] irq_id,
                            input logic [7:0] cause_ip, input logic clear, input logic busy);
      check_output({tag, ".req"},      32'(bus.req),      32'(req));
      check_output({tag, ".irq_id"},   32'(bus.irq_id),   32'(irq_id));
      check_output({tag, ".cause_ip"}, 32'(bus.cause_ip), 32'(cause_ip));
      check_output({tag, ".clear"},    32'(bus.clear),    32'(clear));
      check_output({tag, ".busy"},     32'(bus.busy),     32'(busy));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;

`ifdef INTERRUPT_DISPATCH_ROUND_ROBIN_EN
      rr_exp = '{3'd7, 3'd4, 3'd7};
`else
      rr_exp = '{3'd7, 3'd7, 3'd7};
`endif

      //          pending  im      ie    exl   ack   eret   req   id    cause  clear busy
      vecs[0]  = '{8'h24, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 8'h24, 1'b0, 1'b1};
      vecs[1]  = '{8'h24, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 8'h24, 1'b1, 1'b1};
      vecs[2]  = '{8'h24, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 8'h24, 1'b0, 1'b1};
      vecs[3]  = '{8'h24, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 8'h24, 1'b0, 1'b1};
      vecs[4]  = '{8'h24, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 8'h24, 1'b0, 1'b0};
      vecs[5]  = '{8'h04, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 1'b0, 1'b1};
      vecs[6]  = '{8'h04, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'h04, 1'b0, 1'b0};
      vecs[7]  = '{8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'h04, 1'b0, 1'b0};
      vecs[8]  = '{8'h01, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 8'h04, 1'b0, 1'b0};
      vecs[9]  = '{8'h81, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h81, 1'b0, 1'b1};
      vecs[10] = '{8'h81, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h81, 1'b1, 1'b1};
      vecs[11] = '{8'h81, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h81, 1'b0, 1'b1};
      vecs[12] = '{8'h81, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h81, 1'b0, 1'b0};
      vecs[13] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h81, 1'b0, 1'b0};
      vecs[14] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h81, 1'b0, 1'b0};
      vecs[15] = '{8'h02, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 8'h02, 1'b0, 1'b1};
      vecs[16] = '{8'h02, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 8'h02, 1'b0, 1'b1};
      vecs[17] = '{8'h02, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'h02, 1'b1, 1'b1};
      vecs[18] = '{8'h80, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'h02, 1'b0, 1'b1};
      vecs[19] = '{8'h80, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'h02, 1'b0, 1'b1};

      // Power-on reset: every output low.
      reset = 1'b1;
      apply_stimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      step();
      check_all("reset", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
      reset = 1'b0;

      // Table: inputs held over one rising edge, outputs sampled 1 ns after it.
      for (int i = 0; i < NUM_VECS; i++) begin
         apply_stimulus(vecs[i].pending, vecs[i].im, vecs[i].ie, vecs[i].exl,
                        vecs[i].ack, vecs[i].eret);
         step();
         check_all($sformatf("row%0d", i), vecs[i].req, vecs[i].irq_id,
                   vecs[i].cause_ip, vecs[i].clear, vecs[i].busy);
      end

      // Reset mid-SERVICE (table leaves the FSM in SERVICE), between clock edges.
      #2;
      reset = 1'b1;
      #1;
      check_all("rst_service", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
      apply_stimulus(8'h24, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      step();
      check_all("post_rst_req", 1'b1, 3'd5, 8'h24, 1'b0, 1'b1);

      // Reset mid-REQ, then the first request after release looks like power-on.
      #2;
      reset = 1'b1;
      #1;
      check_all("rst_req", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      step();
      check_all("rereq", 1'b1, 3'd5, 8'h24, 1'b0, 1'b1);

      // Fresh reset, then three service rounds with 8'h90 held pending.
      reset = 1'b1;
      apply_stimulus(8'h90, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      @(negedge clk);
      reset = 1'b0;
      for (int r = 0; r < 3; r++) begin
         apply_stimulus(8'h90, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
         step();
         check_output($sformatf("rr%0d.req", r), 32'(bus.req), 32'd1);
         check_output($sformatf("rr%0d.irq_id", r), 32'(bus.irq_id), 32'(rr_exp[r]));
         apply_stimulus(8'h90, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
         step();
         check_output($sformatf("rr%0d.clear", r), 32'(bus.clear), 32'd1);
         apply_stimulus(8'h90, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
         step();
         check_output($sformatf("rr%0d.svc_req", r), 32'(bus.req), 32'd0);
         apply_stimulus(8'h90, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
         step();
         check_output($sformatf("rr%0d.idle", r), 32'(bus.busy), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/interrupt_dispatcher.md
# interrupt_dispatcher

- Consumer side of the interrupt capture path in the pipeline.
- Takes the registered pending-interrupt vector and gates it with the CP0 Status mask bits (IM, IE, EXL).
- Picks one interrupt, raises a request to the exception unit and holds it until the request is acknowledged or withdrawn.
- After acknowledge, pulses `clear` back to the interrupt storage block, then stays in service until ERET.

## Interface

Parameters:
- N, 8, number of interrupt lines (IP bits)
- IW, $clog2(N), width of the interrupt index

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- pending  in  N  registered pending vector from interrupt storage
- im  in  N  Status.IM mask, 1 = enabled
- ie  in  1  Status.IE
- exl  in  1  Status.EXL
- ack  in  1  exception unit has committed the interrupt exception
- eret  in  1  ERET retired
- req  out  1  interrupt request to exception unit
- irq_id  out  IW  index of the selected interrupt
- cause_ip  out  N  snapshot of `pending` at selection, for Cause.IP
- clear  out  1  one-cycle pulse; clears the storage register
- busy  out  1  state != IDLE

## Operation

- eligible = pending & im; allowed = ie & ~exl.
- FSM states: IDLE, REQ, CLEAR, SERVICE. Reset state is IDLE; all outputs reset to 0.
- IDLE:
  - if allowed & |eligible: latch cause_ip <= pending, irq_id <= pick(eligible), go REQ.
  - otherwise stay; cause_ip and irq_id hold their last values.
- REQ:
  - req = 1; irq_id and cause_ip are frozen.
  - ack = 1 → go CLEAR.
  - ack = 0 and (~allowed or eligible == 0) → withdraw, go IDLE; req drops next cycle.
  - Simultaneous ack and withdraw condition: ack wins.
- CLEAR:
  - clear = 1 for exactly this cycle; req = 0; go SERVICE unconditionally.
- SERVICE:
  - wait for eret; on eret go IDLE.
  - New pending interrupts are not serviced here; they remain in storage.
- ack outside REQ and eret outside SERVICE are ignored.
- pick(): fixed priority, highest index wins (IP7 over IP0). All outputs are registered.

## Timing

- Eligible interrupt sampled in IDLE at cycle t → req = 1 at t+1.
- ack at cycle t (in REQ) → clear = 1 at t+1 → SERVICE at t+2.
- eret at cycle t → IDLE at t+1 → earliest new req at t+2.
- Withdraw condition at cycle t → req = 0 at t+1.
- Reset asserted mid-operation (any state) → IDLE immediately; req, clear, busy go to 0 asynchronously. The rotation pointer also resets.

## Configuration

- Macro: INTERRUPT_DISPATCH_ROUND_ROBIN_EN.
- Defined:
  - pick() uses rotating priority. Register last_id (reset 0) is updated with irq_id on the transition to CLEAR.
  - The search starts at last_id-1 and descends, wrapping from 0 to N-1.
  - After reset the search starts at N-1, identical to fixed priority.
- Undefined: fixed highest-index priority; no last_id register.

## Structure

- Package interrupt_pkg holds:
  - state enum dispatch_state_e {IDLE, REQ, CLEAR, SERVICE}
  - IRQ_N = 8
  - IRQ_IW = $clog2(IRQ_N)
- Sub-module interrupt_priority_picker: combinational.
  - Inputs: eligible[N] and start index.
  - Outputs: valid and index.
  - The macro only changes the start index it is fed.

## Test plan

- Fixed priority: pending=8'h24, im=8'hFF, ie=1, exl=0 → req at +1 with irq_id=5, cause_ip=8'h24.
- Full handshake: ack in REQ → clear high exactly one cycle, busy stays 1; eret → busy 0 next cycle; req not re-raised before eret even with pending held.
- Masking and withdraw:
  - exl=1 with pending=8'h01 → req stays 0.
  - In REQ, ie drops with no ack → req 0 next cycle, clear never pulses.
  - ie drop together with ack → CLEAR is taken.
- Mask filter: pending=8'h81, im=8'h01 → irq_id=0.
- Reset mid-REQ and mid-SERVICE: all outputs 0 asynchronously; after release, the first request behaves as after power-on.
- Round-robin build: pending held at 8'h90 for three service rounds → irq_id 7, 4, 7. Fixed build with the same stimulus → 7, 7, 7.
